// File: rtl/issue_pkg.sv
// Shared types and helpers for the in-order 4-wide issue stage.
// Opcode classes decide which instructions write a register or touch memory.
package issue_pkg;

    localparam int DES_W = 4;
    localparam int BID_W = 3;
    localparam int IMM_W = 5;
    localparam int LANES = 4;
    localparam int NREG  = 2 ** DES_W;

    localparam logic [3:0] OP_LD = 4'b0010;
    localparam logic [3:0] OP_ST = 4'b0100;
    localparam logic [3:0] OP_BR = 4'b1000;

    typedef struct packed {
        logic             vld;
        logic [DES_W-1:0] des;
        logic [DES_W-1:0] s1;
        logic [DES_W-1:0] s2;
        logic [3:0]       op;
        logic [BID_W-1:0] branch;
        logic [IMM_W-1:0] ime;
    } issue_lane_t;

    function automatic logic has_dest(input logic [3:0] op,
                                      input logic [DES_W-1:0] des);
        return !(op == OP_ST || op == OP_BR) && (des != '0);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/hazard_check.sv
// Finds the longest in-order hazard-free prefix of the pending slots.
// Memory ops may only leave from slot 1, so at most one issues per cycle.
module hazard_check
    import issue_pkg::*;
(
    input  issue_lane_t [LANES-1:0] slot,
    input  logic [NREG-1:0]         busy,
    output logic [2:0]              n
);

    logic            ok;
    logic            stop;
    logic [NREG-1:0] wmask;

    always_comb begin
        n     = '0;
        ok    = 1'b0;
        stop  = 1'b0;
        wmask = '0;
        for (int k = 0; k < LANES; k++) begin
            ok = slot[k].vld && !stop;
            if (slot[k].s1 != '0 && (busy[slot[k].s1] || wmask[slot[k].s1]))
                ok = 1'b0;
            if (slot[k].s2 != '0 && (busy[slot[k].s2] || wmask[slot[k].s2]))
                ok = 1'b0;
            if (has_dest(slot[k].op, slot[k].des) &&
                (busy[slot[k].des] || wmask[slot[k].des]))
                ok = 1'b0;
            if (is_mem(slot[k].op) && k != 0)
                ok = 1'b0;
            if (ok) begin
                n = 3'(k + 1);
                if (has_dest(slot[k].op, slot[k].des))
                    wmask[slot[k].des] = 1'b1;
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order 4-wide issue stage with a per-register busy scoreboard.
// Holds one bundle, issues a hazard-free prefix each cycle, compacts the rest.
module issue_scoreboard
    import issue_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_1_vld,
    input  logic [DES_W-1:0] dec_1_des,
    input  logic [DES_W-1:0] dec_1_s1,
    input  logic [DES_W-1:0] dec_1_s2,
    input  logic [3:0]       dec_1_op,
    input  logic [BID_W-1:0] dec_1_branch,
    input  logic [IMM_W-1:0] dec_1_ime,
    input  logic             dec_2_vld,
    input  logic [DES_W-1:0] dec_2_des,
    input  logic [DES_W-1:0] dec_2_s1,
    input  logic [DES_W-1:0] dec_2_s2,
    input  logic [3:0]       dec_2_op,
    input  logic [BID_W-1:0] dec_2_branch,
    input  logic [IMM_W-1:0] dec_2_ime,
    input  logic             dec_3_vld,
    input  logic [DES_W-1:0] dec_3_des,
    input  logic [DES_W-1:0] dec_3_s1,
    input  logic [DES_W-1:0] dec_3_s2,
    input  logic [3:0]       dec_3_op,
    input  logic [BID_W-1:0] dec_3_branch,
    input  logic [IMM_W-1:0] dec_3_ime,
    input  logic             dec_4_vld,
    input  logic [DES_W-1:0] dec_4_des,
    input  logic [DES_W-1:0] dec_4_s1,
    input  logic [DES_W-1:0] dec_4_s2,
    input  logic [3:0]       dec_4_op,
    input  logic [BID_W-1:0] dec_4_branch,
    input  logic [IMM_W-1:0] dec_4_ime,
    output logic             dec_ready,
    input  logic             back_1_vld,
    input  logic [DES_W-1:0] back_1_des,
    input  logic             back_2_vld,
    input  logic [DES_W-1:0] back_2_des,
    input  logic             back_3_vld,
    input  logic [DES_W-1:0] back_3_des,
    input  logic             back_4_vld,
    input  logic [DES_W-1:0] back_4_des,
    output logic             in_1_vld,
    output logic [DES_W-1:0] in_1_des,
    output logic [DES_W-1:0] in_1_s1,
    output logic [DES_W-1:0] in_1_s2,
    output logic [3:0]       in_1_op,
    output logic [BID_W-1:0] in_1_branch,
    output logic [IMM_W-1:0] in_1_ime,
    output logic             in_2_vld,
    output logic [DES_W-1:0] in_2_des,
    output logic [DES_W-1:0] in_2_s1,
    output logic [DES_W-1:0] in_2_s2,
    output logic [3:0]       in_2_op,
    output logic [BID_W-1:0] in_2_branch,
    output logic [IMM_W-1:0] in_2_ime,
    output logic             in_3_vld,
    output logic [DES_W-1:0] in_3_des,
    output logic [DES_W-1:0] in_3_s1,
    output logic [DES_W-1:0] in_3_s2,
    output logic [3:0]       in_3_op,
    output logic [BID_W-1:0] in_3_branch,
    output logic [IMM_W-1:0] in_3_ime,
    output logic             in_4_vld,
    output logic [DES_W-1:0] in_4_des,
    output logic [DES_W-1:0] in_4_s1,
    output logic [DES_W-1:0] in_4_s2,
    output logic [3:0]       in_4_op,
    output logic [BID_W-1:0] in_4_branch,
    output logic [IMM_W-1:0] in_4_ime,
    output logic [15:0]      stall_cnt
);

    issue_lane_t [LANES-1:0]  dec, pend, pend_nxt, iss, iss_nxt;
    logic [LANES-1:0]         bvld;
    logic [LANES-1:0][DES_W-1:0] bdes;
    logic [NREG-1:0]          busy, busy_nxt;
    logic [2:0]               n, cnt;
    logic                     accept;

    assign dec[0] = '{dec_1_vld, dec_1_des, dec_1_s1, dec_1_s2,
                      dec_1_op, dec_1_branch, dec_1_ime};
    assign dec[1] = '{dec_2_vld, dec_2_des, dec_2_s1, dec_2_s2,
                      dec_2_op, dec_2_branch, dec_2_ime};
    assign dec[2] = '{dec_3_vld, dec_3_des, dec_3_s1, dec_3_s2,
                      dec_3_op, dec_3_branch, dec_3_ime};
    assign dec[3] = '{dec_4_vld, dec_4_des, dec_4_s1, dec_4_s2,
                      dec_4_op, dec_4_branch, dec_4_ime};

    assign bvld = {back_4_vld, back_3_vld, back_2_vld, back_1_vld};
    assign bdes = {back_4_des, back_3_des, back_2_des, back_1_des};

    assign {in_1_vld, in_1_des, in_1_s1, in_1_s2,
            in_1_op, in_1_branch, in_1_ime} = iss[0];
    assign {in_2_vld, in_2_des, in_2_s1, in_2_s2,
            in_2_op, in_2_branch, in_2_ime} = iss[1];
    assign {in_3_vld, in_3_des, in_3_s1, in_3_s2,
            in_3_op, in_3_branch, in_3_ime} = iss[2];
    assign {in_4_vld, in_4_des, in_4_s1, in_4_s2,
            in_4_op, in_4_branch, in_4_ime} = iss[3];

    hazard_check u_hazard (
        .slot (pend),
        .busy (busy),
        .n    (n)
    );

    always_comb begin
        cnt = '0;
        for (int k = 0; k < LANES; k++)
            if (pend[k].vld) cnt = cnt + 3'd1;
    end

    // Empty buffer gives n == cnt == 0, so one compare covers both cases.
    assign dec_ready = (n == cnt);
    assign accept    = dec_ready && (|{dec_1_vld, dec_2_vld, dec_3_vld, dec_4_vld});

    always_comb begin
        pend_nxt = '0;
        iss_nxt  = '0;
        busy_nxt = busy;
        for (int k = 0; k < LANES; k++) begin
            automatic int j = k + int'(n);
            if (j < LANES) pend_nxt[k] = pend[j[1:0]];
            if (k < int'(n)) iss_nxt[k] = pend[k];
        end
        if (accept)
            for (int k = 0; k < LANES; k++)
                pend_nxt[k] = dec[k].vld ? dec[k] : '0;
        for (int k = 0; k < LANES; k++)
            if (bvld[k]) busy_nxt[bdes[k]] = 1'b0;
        // Set after clear so a same-edge writeback cannot hide a new writer.
        for (int k = 0; k < LANES; k++)
            if (k < int'(n) && has_dest(pend[k].op, pend[k].des))
                busy_nxt[pend[k].des] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            iss       <= '0;
            busy      <= '0;
            stall_cnt <= '0;
        end else begin
            pend <= pend_nxt;
            iss  <= iss_nxt;
            busy <= busy_nxt;
            if (cnt != '0 && n == '0 && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- In-order 4-wide issue stage directly upstream of the register file; drives its in_<i>_* ports.
- Holds one decoded bundle and tracks a busy bit per architectural register, set at issue and cleared at writeback.
- Each cycle it issues the longest in-order hazard-free prefix of pending instructions. Any load/store always leaves on lane 1.
- Un-issued instructions are compacted toward lane 1 and retried; a new bundle is accepted only when the held one fully drains.

Parameters:
- DES_W, 4, register index width (regs 0..2**DES_W-1, reg0 hard zero)
- BID_W, 3, branch-id width
- IMM_W, 5, immediate width
- LANES, 4, issue width (fixed; ports are enumerated per lane)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_<i>_vld  in  1  decode lane i valid (i=1..4); lanes valid as a contiguous prefix
- dec_<i>_des / dec_<i>_s1 / dec_<i>_s2  in  DES_W each  dest / source indices
- dec_<i>_op  in  4  opcode
- dec_<i>_branch  in  BID_W  branch id
- dec_<i>_ime  in  IMM_W  immediate
- dec_ready  out  1  bundle accepted at this edge when dec_ready && any dec_<i>_vld
- back_<i>_vld / back_<i>_des  in  1 / DES_W  writeback notifications, same signals as the register-file writeback
- in_<i>_vld, in_<i>_des, in_<i>_s1, in_<i>_s2, in_<i>_op, in_<i>_branch, in_<i>_ime  out  as dec_  registered issue lanes to the register file
- stall_cnt  out  16  saturating count of cycles with pending work but zero issued

Behaviour:
- Reset (rst_n low, async): pending buffer empty, all busy bits 0, all in_<i>_* outputs 0, stall_cnt 0, dec_ready 1 once reset is released.
- Pending buffer: 4 slots, slot 1 oldest. Loaded from dec_* at the accepting edge, shifted down by the issued count otherwise.
- has_dest(op) is false for OP_ST and OP_BR, and false when des==0.
- Hazard rules for pending slot k, evaluated on current busy bits (registered, no bypass):
  - RAW: s1 or s2 nonzero and busy.
  - WAW: has_dest and des busy.
  - Intra-group: s1, s2 or des equals the des of an earlier slot issuing this cycle.
- Memory rule: op OP_LD/OP_ST issues only from slot 1; a memory op in slot k>1 ends the group. At most one memory op per cycle.
- Issue group: slots 1..n, where n is the first slot failing a rule, minus 1. Group lanes are registered onto in_1..in_n with vld=1; remaining lanes get vld=0 and zeroed fields.
- Latency: decode accept at edge E issues no earlier than edge E+1; register-file read occurs in the cycle after issue.
- Busy update at each edge: set for each issued has_dest des, clear for each back_<i>_vld des. Set and clear of the same register at the same edge: set wins. back_des==0 is ignored.
- dec_ready (comb) = buffer empty OR all valid pending slots issue this cycle. Accepting and issuing the last slots on the same edge is legal; the new bundle occupies slots 1..m.
- stall_cnt increments when the buffer is non-empty and n==0, and saturates at 16'hFFFF.
- Reset mid-operation discards the pending bundle and busy bits immediately; in-flight writebacks after reset are harmless (clear of a 0 bit).

Decomposition:
- Package issue_pkg holds:
  - opcode constants OP_LD=4'b0010, OP_ST=4'b0100, OP_BR=4'b1000
  - function has_dest and function is_mem
  - typedef issue_lane_t (vld, des, s1, s2, op, branch, ime)
- Sub-module hazard_check: combinational; takes pending slots plus busy vector and returns issue count n.

Test Plan:
- Independent bundle r1=r2+r3, r4=r5+r6, r7=r8+r9, r10=r11+r12 with busy clear -> all four issue next edge on lanes 1..4; busy {1,4,7,10} set; dec_ready=1.
- Bundle r1=r2+r3, r5=r1+r4 -> lane 1 only. Slot 2 waits until back_1_vld with des=1, then issues on lane 1 at the edge following the clear; stall_cnt increments during the wait.
- Bundle ADD r1, LD r2 -> ADD issues alone; LD issues on lane 1 next cycle. Bundle LD, ST -> two cycles, both on lane 1.
- Writeback of r3 and issue of a new writer of r3 on the same edge -> busy[3]=1 afterward.
- Source or dest r0 with busy state arbitrary -> never a hazard; busy[0] stays 0.
- rst_n low while 2 slots pending and busy[5]=1 -> all outputs 0 immediately, busy clear, dec_ready=1 after release.
